hilf_shaper: RTL

HILF_SHAPER -- requirements
Module: hilf_shaper

---
 rtl/hilf_shaper.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hilf_shaper.sv
// hilf_shaper: per-channel integrating noise-shaper with min normalisation.
// Each stage adds its input to a per-channel state, clamps to 2^W-1, then
// subtracts the minimum over all channels so at least one channel is zero.
// ORDER=2 cascades a second stage fed by the first stage's output.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   valid_in   st is valid; filter state advances only when high
//   st         N-bit up-transition vector, bit i = channel i
//   clr_sat    synchronous clear of sat_cnt (wins over increment)
//   sfi        registered filter outputs, channel i at sfi[i*W +: W]
//   su         registered minimum subtracted by the final stage
//   valid_out  sfi/su updated this cycle
//   sat_flag   at least one channel clamped in the sample now on sfi
//   sat_cnt    saturating count of clamped samples
module hilf_shaper #(
   parameter int unsigned N     = 18,
   parameter int unsigned W     = 4,
   parameter int unsigned ORDER = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [N-1:0]     st,
   input  logic             clr_sat,
   output logic [N*W-1:0]   sfi,
   output logic [W-1:0]     su,
   output logic             valid_out,
   output logic             sat_flag,
   output logic [7:0]       sat_cnt
);

   generate
      if (ORDER != 1 && ORDER != 2) begin : g_bad_order
         $error("hilf_shaper: ORDER must be 1 or 2");
      end
   endgenerate

   localparam logic [W:0] MAXV    = (W+1)'((1 << W) - 1);
   localparam logic [7:0] CNT_MAX = 8'hFF;

   logic [W-1:0]   fid1 [N];
   logic [W-1:0]   fid2 [N];
   logic [W:0]     sr1  [N];
   logic [W:0]     sr2  [N];
   logic [W-1:0]   c1   [N];
   logic [W-1:0]   c2   [N];
   logic [W-1:0]   fi1  [N];
   logic [W-1:0]   fi2  [N];
   logic [W-1:0]   su1;
   logic [W-1:0]   su2;
   logic           sat1;
   logic           sat2;
   logic           sat;
   logic [N*W-1:0] sfi_nxt;
   logic [W-1:0]   su_nxt;

   // Stage 1: integrate st, clamp, normalise by channel minimum
   always_comb begin
      su1  = '1;
      sat1 = 1'b0;
      for (int i = 0; i < N; i++) begin
         sr1[i] = {1'b0, fid1[i]} + (W+1)'(st[i]);
         if (sr1[i] > MAXV) begin
            c1[i] = MAXV[W-1:0];
            sat1  = 1'b1;
         end else begin
            c1[i] = sr1[i][W-1:0];
         end
         if (c1[i] < su1) su1 = c1[i];
      end
      for (int i = 0; i < N; i++) begin
         fi1[i] = c1[i] - su1;
      end
   end

   // Stage 2: same shape, fed by stage 1 output (only observed when ORDER=2)
   always_comb begin
      su2  = '1;
      sat2 = 1'b0;
      for (int i = 0; i < N; i++) begin
         sr2[i] = {1'b0, fid2[i]} + {1'b0, fi1[i]};
         if (sr2[i] > MAXV) begin
            c2[i] = MAXV[W-1:0];
            sat2  = 1'b1;
         end else begin
            c2[i] = sr2[i][W-1:0];
         end
         if (c2[i] < su2) su2 = c2[i];
      end
      for (int i = 0; i < N; i++) begin
         fi2[i] = c2[i] - su2;
      end
   end

   // Final-stage selection and packing
   always_comb begin
      sfi_nxt = '0;
      for (int i = 0; i < N; i++) begin
         sfi_nxt[i*W +: W] = (ORDER == 2) ? fi2[i] : fi1[i];
      end
      su_nxt = (ORDER == 2) ? su2 : su1;
      sat    = sat1 | ((ORDER == 2) & sat2);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            fid1[i] <= '0;
            fid2[i] <= '0;
         end
         sfi       <= '0;
         su        <= '0;
         sat_flag  <= 1'b0;
         valid_out <= 1'b0;
         sat_cnt   <= '0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            for (int i = 0; i < N; i++) begin
               fid1[i] <= fi1[i];
               fid2[i] <= fi2[i];
            end
            sfi      <= sfi_nxt;
            su       <= su_nxt;
            sat_flag <= sat;
         end
         if (clr_sat) begin
            sat_cnt <= '0;
         end else if (valid_in && sat && sat_cnt != CNT_MAX) begin
            sat_cnt <= sat_cnt + 8'd1;
         end
      end
   end

endmodule
